// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//   UART receiver with a small first-word-fall-through receive FIFO.
//   The serial line passes through a 2-flop synchroniser. A bit-timing FSM
//   finds the start bit and samples each bit in the middle of its period.
//   Good words go into the FIFO. Framing, overrun and (optionally) parity
//   errors are reported as 1-cycle pulses.
//
//   Optional feature macro: UART_RX_PARITY_EN
//     defined   : one parity bit follows the data bits (even/odd per PARITY_ODD)
//     undefined : no parity bit in the frame, parity_err_o is constant 0
//
// Parameters
//   CLK_DIV     clk cycles per serial bit (>= 4)
//   DATA_W      data bits per frame (5..9), LSB first
//   STOP_BITS   stop bits checked (1 or 2)
//   FIFO_DEPTH  receive FIFO words (power of 2, >= 2)
//   PARITY_ODD  0 = even parity, 1 = odd parity
//
// Ports
//   clk_i          system clock, rising edge
//   reset_i        synchronous active-high reset
//   din_i          asynchronous serial input, idle high
//   rx_data_o      FIFO head word (meaningful while rx_valid_o)
//   rx_valid_o     FIFO not empty
//   rx_ready_i     consumer pops the head when rx_valid_o && rx_ready_i
//   fifo_count_o   number of words held
//   frame_err_o    pulse: a stop bit was sampled low, word discarded
//   overrun_o      pulse: a good word was dropped because the FIFO was full
//   parity_err_o   pulse: parity mismatch, word discarded
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
   parameter int CLK_DIV    = 10416,
   parameter int DATA_W     = 8,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4,
   parameter int PARITY_ODD = 0
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          din_i,
   output logic [DATA_W-1:0]             rx_data_o,
   output logic                          rx_valid_o,
   input  logic                          rx_ready_i,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
   output logic                          frame_err_o,
   output logic                          overrun_o,
   output logic                          parity_err_o
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int BIT_W = $clog2(DATA_W + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2 - 1);
   localparam logic [DIV_W-1:0] DIV_FULL = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
   localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_STOP   = 3'd3;
   localparam logic [2:0] S_BREAK  = 3'd4;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd5;

   // True when data plus received parity bit do not match the configured sense.
   function automatic logic parity_bad(input logic [DATA_W-1:0] data, input logic pbit);
      return (^{data, pbit}) != (PARITY_ODD != 0);
   endfunction
`else
   logic unused_parity_cfg_s;
   assign unused_parity_cfg_s = (PARITY_ODD != 0);
`endif

   // ------------------------------------------------------------------------
   // Receiver state
   // ------------------------------------------------------------------------
   logic              sync1_q, sync2_q;
   logic              ds_s;
   logic [2:0]        state_q, state_d;
   logic [DIV_W-1:0]  divcnt_q, divcnt_d;
   logic [BIT_W-1:0]  bitcnt_q, bitcnt_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              stop_bad_q, stop_bad_d;
   logic              stop_bad_s;
   logic              push_s, ferr_s;
`ifdef UART_RX_PARITY_EN
   logic              perr_q, perr_d;
   logic              perr_s;
`endif

   assign ds_s = sync2_q;
   // Any low stop sample so far (including this one) marks the frame bad.
   assign stop_bad_s = stop_bad_q | ~ds_s;

   // Two-flop synchroniser for the asynchronous serial line.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= din_i;
         sync2_q <= sync1_q;
      end
   end

   // Bit-timing FSM next-state and frame decision.
   always_comb begin
      state_d    = state_q;
      divcnt_d   = divcnt_q;
      bitcnt_d   = bitcnt_q;
      shift_d    = shift_q;
      stop_bad_d = stop_bad_q;
      push_s     = 1'b0;
      ferr_s     = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_d     = perr_q;
      perr_s     = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (!ds_s) begin
               state_d    = S_START;
               divcnt_d   = {DIV_W{1'b0}};
               bitcnt_d   = {BIT_W{1'b0}};
               stop_bad_d = 1'b0;
`ifdef UART_RX_PARITY_EN
               perr_d     = 1'b0;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         // Half a bit in: a high line here was only a glitch.
         S_START: begin
            if (divcnt_q == DIV_HALF) begin
               divcnt_d = {DIV_W{1'b0}};
               if (ds_s) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DATA;
               end
            end else begin
               divcnt_d = divcnt_q + DIV_W'(1);
            end
         end
         S_DATA: begin
            if (divcnt_q == DIV_FULL) begin
               divcnt_d = {DIV_W{1'b0}};
               // LSB arrives first, so shift in from the top.
               shift_d  = {ds_s, shift_q[DATA_W-1:1]};
               if (bitcnt_q == DATA_LAST) begin
                  bitcnt_d = {BIT_W{1'b0}};
`ifdef UART_RX_PARITY_EN
                  state_d  = S_PARITY;
`else
                  state_d  = S_STOP;
`endif
               end else begin
                  bitcnt_d = bitcnt_q + BIT_W'(1);
               end
            end else begin
               divcnt_d = divcnt_q + DIV_W'(1);
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (divcnt_q == DIV_FULL) begin
               divcnt_d = {DIV_W{1'b0}};
               perr_d   = parity_bad(shift_q, ds_s);
               state_d  = S_STOP;
            end else begin
               divcnt_d = divcnt_q + DIV_W'(1);
            end
         end
`endif
         // Decision is made at the middle of the last stop bit so the next
         // start edge is found even with a few percent of baud mismatch.
         S_STOP: begin
            if (divcnt_q == DIV_FULL) begin
               divcnt_d = {DIV_W{1'b0}};
               if (bitcnt_q == STOP_LAST) begin
                  bitcnt_d   = {BIT_W{1'b0}};
                  stop_bad_d = 1'b0;
                  if (stop_bad_s) begin
                     ferr_s  = 1'b1;
                     state_d = S_BREAK;
                  end
`ifdef UART_RX_PARITY_EN
                  else if (perr_q) begin
                     perr_s  = 1'b1;
                     state_d = S_IDLE;
                  end
`endif
                  else begin
                     push_s  = 1'b1;
                     state_d = S_IDLE;
                  end
               end else begin
                  bitcnt_d   = bitcnt_q + BIT_W'(1);
                  stop_bad_d = stop_bad_s;
               end
            end else begin
               divcnt_d = divcnt_q + DIV_W'(1);
            end
         end
         // Line held low after a framing error: wait for idle before re-arming.
         S_BREAK: begin
            if (ds_s) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_BREAK;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Receiver FSM registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= S_IDLE;
         divcnt_q   <= {DIV_W{1'b0}};
         bitcnt_q   <= {BIT_W{1'b0}};
         shift_q    <= {DATA_W{1'b0}};
         stop_bad_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         divcnt_q   <= divcnt_d;
         bitcnt_q   <= bitcnt_d;
         shift_q    <= shift_d;
         stop_bad_q <= stop_bad_d;
`ifdef UART_RX_PARITY_EN
         perr_q     <= perr_d;
`endif
      end
   end

   // ------------------------------------------------------------------------
   // Receive FIFO (first-word-fall-through)
   // ------------------------------------------------------------------------
   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              pop_s, full_s, wr_en_s, ovr_s;
   logic              frame_err_q, overrun_q;

   assign pop_s   = (count_q != {CNT_W{1'b0}}) && rx_ready_i;
   assign full_s  = (count_q == CNT_FULL);
   // When full, a same-cycle pop frees the slot the push needs.
   assign wr_en_s = push_s && (!full_s || pop_s);
   assign ovr_s   = push_s && full_s && !pop_s;
   assign count_d = count_q + CNT_W'(wr_en_s) - CNT_W'(pop_s);

   // FIFO storage, pointers and occupancy.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= {DATA_W{1'b0}};
         end
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {CNT_W{1'b0}};
      end else begin
         if (wr_en_s) begin
            mem_q[wr_ptr_q] <= shift_q;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         count_q <= count_d;
      end
   end

   // Error pulse registers, aligned with the cycle a push would become visible.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         frame_err_q <= ferr_s;
         overrun_q   <= ovr_s;
      end
   end

`ifdef UART_RX_PARITY_EN
   logic parity_err_q;

   // Parity error pulse register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         parity_err_q <= 1'b0;
      end else begin
         parity_err_q <= perr_s;
      end
   end

   assign parity_err_o = parity_err_q;
`else
   assign parity_err_o = 1'b0;
`endif

   assign rx_data_o    = mem_q[rd_ptr_q];
   assign rx_valid_o   = (count_q != {CNT_W{1'b0}});
   assign fifo_count_o = count_q;
   assign frame_err_o  = frame_err_q;
   assign overrun_o    = overrun_q;

endmodule
